// File: rtl/shift_pkg.sv
// Shared definitions for the shift execute stage: opcodes, shifter control
// decode and the output-skid state encoding.
package shift_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_LSL = 3'd0;
  localparam logic [OP_W-1:0] OP_LSR = 3'd1;
  localparam logic [OP_W-1:0] OP_ASR = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic rot;
    logic left;
    logic sign;
  } shift_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_ROR);
  endfunction

  // Illegal opcodes decode to a plain right shift; the stage overrides the result.
  function automatic shift_ctrl_t decode_op(input logic [OP_W-1:0] op);
    shift_ctrl_t c;
    c.rot  = 1'b0;
    c.left = 1'b0;
    c.sign = 1'b0;
    case (op)
      OP_LSL: c.left = 1'b1;
      OP_ASR: c.sign = 1'b1;
      OP_ROL: begin
        c.rot  = 1'b1;
        c.left = 1'b1;
      end
      OP_ROR: c.rot = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shifter.sv
// Shared combinational barrel shifter: logical/arithmetic shifts and rotates
// selected by rot/left/sign.
module shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic             rot,
  input  logic             left,
  input  logic             sign,
  output logic [WIDTH-1:0] y
);

  logic [SHW-1:0]   w_inv_b;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  // WIDTH - b wraps to 0 when b == 0, so the OR below degenerates to a | a.
  assign w_inv_b = SHW'(WIDTH - int'(b));
  assign w_rol   = (a << b) | (a >> w_inv_b);
  assign w_ror   = (a >> b) | (a << w_inv_b);

  always_comb begin
    y = a >> b;
    if (rot) begin
      y = left ? w_rol : w_ror;
    end else if (left) begin
      y = a << b;
    end else if (sign) begin
      y = WIDTH'($signed(a) >>> b);
    end
  end

endmodule

// File: rtl/skid_reg2.sv
// Generic two-entry valid/ready skid register; in_ready and out_valid come
// straight from flops so neither side sees a combinational path.
module skid_reg2
  import shift_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic [W-1:0] r_out;
  logic [W-1:0] w_out_nxt;
  logic [W-1:0] r_skid;
  logic [W-1:0] w_skid_nxt;
  logic         r_in_ready;
  logic         w_in_ready_nxt;
  logic         r_out_valid;
  logic         w_out_valid_nxt;
  logic         w_acc;
  logic         w_emit;

  assign w_acc  = in_valid && r_in_ready;
  assign w_emit = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_skid_nxt      = r_skid;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_out_nxt       = in_data;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_emit) begin
          w_out_nxt = in_data;
        end else if (w_acc) begin
          // Consumer stalled: park the new result and close the input.
          w_skid_nxt     = in_data;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = ST_TWO;
        end else if (w_emit) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_emit) begin
          w_out_nxt      = r_skid;
          w_in_ready_nxt = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: begin
        w_state_nxt     = ST_EMPTY;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule

// File: rtl/shift_stage.sv
// Registered, handshaked shift execute stage: decodes the opcode for the shared
// shifter, computes carry/zero/negative/illegal and queues results in a skid.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_illegal
);

  localparam int unsigned PW = WIDTH + 4;

  shift_ctrl_t      w_ctrl;
  logic             w_legal;
  logic [WIDTH-1:0] w_shift_y;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic [SHW-1:0]   w_lsl_idx;
  logic [SHW-1:0]   w_lsr_idx;
  logic [PW-1:0]    w_in_data;
  logic [PW-1:0]    w_out_data;

  assign w_ctrl  = decode_op(in_op);
  assign w_legal = op_is_legal(in_op);

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .a    (in_a),
    .b    (in_b),
    .rot  (w_ctrl.rot),
    .left (w_ctrl.left),
    .sign (w_ctrl.sign),
    .y    (w_shift_y)
  );

  // Last bit shifted out: a[WIDTH-b] for left shifts, a[b-1] for right shifts.
  assign w_lsl_idx = SHW'(WIDTH - int'(in_b));
  assign w_lsr_idx = in_b - SHW'(1);

  always_comb begin
    w_res   = w_shift_y;
    w_carry = in_carry;
    if (!w_legal) begin
      w_res = in_a;
    end else if (in_b != '0) begin
      case (in_op)
        OP_LSL:         w_carry = in_a[w_lsl_idx];
        OP_LSR, OP_ASR: w_carry = in_a[w_lsr_idx];
        OP_ROL:         w_carry = w_res[0];
        OP_ROR:         w_carry = w_res[WIDTH-1];
        default: ;
      endcase
    end
  end

  assign w_in_data = {~w_legal, w_res[WIDTH-1], (w_res == '0), w_carry, w_res};

  skid_reg2 #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign out_illegal = w_out_data[WIDTH+3];
  assign out_neg     = w_out_data[WIDTH+2];
  assign out_zero    = w_out_data[WIDTH+1];
  assign out_carry   = w_out_data[WIDTH];
  assign out_res     = w_out_data[WIDTH-1:0];

endmodule

// File: tb/tb_shift_stage.sv
// Scoreboard bench for shift_stage: driver pushes expected payloads on accept,
// a negedge monitor pops and compares on every emitted result.
module tb_shift_stage;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned PW = W + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [SW-1:0] in_b;
  logic          in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          out_carry;
  logic          out_zero;
  logic          out_neg;
  logic          out_illegal;

  always #5 clk = ~clk;

  shift_stage #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_carry   (out_carry),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_illegal (out_illegal)
  );

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: shift one bit at a time; carry is the last bit moved out.
  function automatic logic [PW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input int b, input logic cin);
    logic [W-1:0] r;
    logic         c;
    logic         ill;
    r   = a;
    c   = cin;
    ill = (op > 3'd4);
    if (!ill) begin
      for (int i = 0; i < b; i++) begin
        case (op)
          3'd0: begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
          3'd1: begin c = r[0];   r = {1'b0, r[W-1:1]}; end
          3'd2: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
          3'd3: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
          default: begin c = r[0]; r = {r[0], r[W-1:1]}; end
        endcase
      end
    end
    return {ill, r[W-1], (r == '0), c, r};
  endfunction

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [SW-1:0] b,
                      input logic cin, input logic [PW-1:0] exp, output int waits);
    bit acc;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_carry = cin;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits <= 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else waits++;
    end
    if (acc) sb.push_back(exp);
    else chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waits);
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [SW-1:0] b;
    logic          c;
    op = 3'($urandom_range(0, 7));
    a  = W'($urandom);
    b  = SW'($urandom_range(0, W - 1));
    c  = 1'($urandom_range(0, 1));
    send(op, a, b, c, model(op, a, int'(b), c), waits);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare emitted results in order and check stability under stall.
  initial begin
    logic [PW-1:0] cur;
    logic [PW-1:0] prev;
    bit hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        cur = {out_illegal, out_neg, out_zero, out_carry, out_res};
        if (hold) chk("stable", {19'd0, out_valid, cur}, {19'd0, 1'b1, prev});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
          else chk("result", 32'(cur), 32'(sb.pop_front()));
        end
        hold = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]    d_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd0, 3'd6};
  logic [W-1:0]  d_a   [8] = '{8'h87, 8'h87, 8'h87, 8'h87, 8'h87, 8'h87, 8'h80, 8'h5A};
  logic [SW-1:0] d_b   [8] = '{3'd3, 3'd1, 3'd2, 3'd1, 3'd4, 3'd0, 3'd1, 3'd2};
  logic          d_c   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [PW-1:0] d_exp [8] = '{12'h038, 12'h143, 12'h5E1, 12'h10F,
                               12'h078, 12'h587, 12'h300, 12'h85A};

  initial begin
    int  w;
    int  wsum;
    bit  done;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_payload", {20'd0, out_illegal, out_neg, out_zero, out_carry, out_res}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors, each into an empty stage to observe one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      send(d_op[i], d_a[i], d_b[i], d_c[i], d_exp[i], w);
      chk("latency_valid", 32'(out_valid), 32'd1);
      drain();
    end

    // Back-pressure: two accepts fill the stage, the third waits.
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    fork
      send_rand(w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Streaming at full rate.
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      send_rand(w);
      wsum += w;
    end
    chk("stream_no_stall", 32'(wsum), 32'd0);
    drain();

    // Random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(w);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Async reset while both entries are full.
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    chk("two_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(3'd4, 8'h87, 3'd4, 1'b1, 12'h078, w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
